// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: multi-operand accumulator built on a 3:2 carry-save adder.
// Operands stream in per group; one carry-propagate add resolves each group.
module csa_accum_ctrl #(
  parameter int width    = 16,
  parameter int cntWidth = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Clr,
  input  logic                InValid,
  output logic                InReady,
  input  logic [width-1:0]    InData,
  input  logic                InLast,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [width-1:0]    OutData,
  output logic [cntWidth-1:0] OutCount,
  output logic                OutSat
);

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RES = 2'd1,
    OUT = 2'd2
  } state_t;

  localparam logic [cntWidth-1:0] CMAX = {cntWidth{1'b1}};

  state_t              state;
  logic [width-1:0]    s;
  logic [width-1:0]    c;
  logic [cntWidth-1:0] cnt;
  logic [width-1:0]    res;
  logic [cntWidth-1:0] res_cnt;
  logic                res_sat;
  logic                in_rdy;
  logic                out_vld;

  logic [width-1:0]    s_nxt;
  logic [width-1:0]    c_nxt;
  logic [cntWidth-1:0] cnt_inc;

  // 3:2 compression of the redundant pair with the incoming operand
  always_comb begin
    s_nxt   = s ^ c ^ InData;
    c_nxt   = ((s & c) | (s & InData) | (c & InData)) << 1;
    cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;
  end

  // Group sequencer with registered handshake and result outputs
  always_ff @(posedge CLK) begin
    if (RST || Clr) begin
      state   <= ACC;
      s       <= '0;
      c       <= '0;
      cnt     <= '0;
      res     <= '0;
      res_cnt <= '0;
      res_sat <= 1'b0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (InValid) begin
            s   <= s_nxt;
            c   <= c_nxt;
            cnt <= cnt_inc;
            if (InLast) begin
              state  <= RES;
              in_rdy <= 1'b0;
            end
          end
        end
        RES: begin
          res     <= s + c;
          res_cnt <= cnt;
          res_sat <= (cnt == CMAX);
          out_vld <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (OutReady) begin
            s       <= '0;
            c       <= '0;
            cnt     <= '0;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= ACC;
          end
        end
        default: begin
          state   <= ACC;
          in_rdy  <= 1'b1;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = in_rdy;
  assign OutValid = out_vld;
  assign OutData  = res;
  assign OutCount = res_cnt;
  assign OutSat   = res_sat;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: random and directed checks of csa_accum_ctrl.
// Two instances (cntWidth 8 and 2) share one stimulus stream.
module tb_csa_accum_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Clr = 1'b0;
  logic       InValid = 1'b0;
  logic       InLast = 1'b0;
  logic       OutReady = 1'b0;
  logic [7:0] InData = '0;

  logic       rdy8, vld8, sat8;
  logic [7:0] data8, cnt8;
  logic       rdy2, vld2, sat2;
  logic [7:0] data2;
  logic [1:0] cnt2;

  always #5 CLK = ~CLK;

  csa_accum_ctrl #(.width(8), .cntWidth(8)) dut8 (
    .CLK(CLK), .RST(RST), .Clr(Clr),
    .InValid(InValid), .InReady(rdy8),
    .InData(InData), .InLast(InLast),
    .OutValid(vld8), .OutReady(OutReady),
    .OutData(data8), .OutCount(cnt8), .OutSat(sat8)
  );

  csa_accum_ctrl #(.width(8), .cntWidth(2)) dut2 (
    .CLK(CLK), .RST(RST), .Clr(Clr),
    .InValid(InValid), .InReady(rdy2),
    .InData(InData), .InLast(InLast),
    .OutValid(vld2), .OutReady(OutReady),
    .OutData(data2), .OutCount(cnt2), .OutSat(sat2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: phase 0 taking operands, 1 resolving, 2 presenting
  int         ph = 0;
  int         msum = 0;
  int         mn = 0;
  logic [7:0] mod = '0;
  int         mc8 = 0;
  int         mc2 = 0;
  bit         armed = 1'b0;

  always @(posedge CLK) begin
    armed <= 1'b1;
    if (RST || Clr) begin
      ph <= 0; msum <= 0; mn <= 0;
      mod <= '0; mc8 <= 0; mc2 <= 0;
    end else begin
      case (ph)
        0: if (InValid) begin
          msum <= (msum + int'(InData)) % 256;
          mn   <= mn + 1;
          if (InLast) ph <= 1;
        end
        1: begin
          mod <= msum[7:0];
          mc8 <= (mn > 255) ? 255 : mn;
          mc2 <= (mn > 3) ? 3 : mn;
          ph  <= 2;
        end
        default: if (OutReady) begin
          ph <= 0; msum <= 0; mn <= 0;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("in_ready8", rdy8, ph == 0);
      chk("out_valid8", vld8, ph == 2);
      chk("out_data8", data8, mod);
      chk("out_count8", cnt8, mc8);
      chk("out_sat8", sat8, mc8 == 255);
      chk("in_ready2", rdy2, ph == 0);
      chk("out_valid2", vld2, ph == 2);
      chk("out_data2", data2, mod);
      chk("out_count2", cnt2, mc2);
      chk("out_sat2", sat2, mc2 == 3);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(logic [7:0] d, bit last, bit gaps);
    bit ok;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        InValid = 1'b0;
        InData  = 8'($urandom);
        InLast  = 1'($urandom);
        tick();
      end
    end
    InValid = 1'b1;
    InData  = d;
    InLast  = last;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (rdy8) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic collect(logic [7:0] exp_d, int exp_n, int hold);
    bit ok;
    int lat;
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      lat++;
      if (vld8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("result_timeout", 0, 1);
    end else begin
      chk("latency", lat, 2);
      chk("group_data", data8, exp_d);
      chk("group_count8", cnt8, (exp_n > 255) ? 255 : exp_n);
      chk("group_sat8", sat8, exp_n >= 255);
      chk("group_count2", cnt2, (exp_n > 3) ? 3 : exp_n);
      chk("group_sat2", sat2, exp_n >= 3);
    end
    repeat (hold) begin
      InValid = 1'($urandom);
      InData  = 8'($urandom);
      InLast  = 1'($urandom);
      @(negedge CLK);
      chk("hold_data", data8, exp_d);
      chk("hold_in_ready", rdy8, 0);
    end
    InValid  = 1'b0;
    InLast   = 1'b0;
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic run_group(logic [7:0] q[$], logic [7:0] exp_d,
                           bit gaps, int hold);
    for (int i = 0; i < q.size(); i++)
      send(q[i], i == q.size() - 1, gaps);
    collect(exp_d, q.size(), hold);
  endtask

  task automatic rand_group(int n, bit gaps, int hold);
    logic [7:0] q[$];
    int sum;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      q.push_back(8'($urandom));
      sum += int'(q[i]);
    end
    run_group(q, 8'(sum % 256), gaps, hold);
  endtask

  initial begin
    logic [7:0] q[$];
    bit ok;

    repeat (2) tick();
    @(negedge CLK);
    chk("reset_valid", vld8, 0);
    chk("reset_ready", rdy8, 1);
    chk("reset_data", data8, 0);
    chk("reset_count", cnt8, 0);
    chk("reset_sat", sat8, 0);
    tick();
    RST = 1'b0;

    q = '{8'd3, 8'd5, 8'd7};
    run_group(q, 8'd15, 1'b0, 0);

    q = '{8'd200, 8'd100};
    run_group(q, 8'd44, 1'b0, 0);

    q = '{8'hFF};
    run_group(q, 8'hFF, 1'b0, 0);
    rand_group(16, 1'b0, 0);

    q = '{8'd9, 8'd10};
    run_group(q, 8'd19, 1'b0, 5);
    q = '{8'd2, 8'd2};
    run_group(q, 8'd4, 1'b0, 0);

    send(8'd11, 1'b0, 1'b0);
    send(8'd12, 1'b0, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_valid", vld8, 0);
    chk("rst_mid_ready", rdy8, 1);
    tick();
    q = '{8'd1};
    run_group(q, 8'd1, 1'b0, 0);

    send(8'd21, 1'b0, 1'b0);
    send(8'd22, 1'b0, 1'b0);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    @(negedge CLK);
    chk("clr_mid_valid", vld8, 0);
    chk("clr_mid_ready", rdy8, 1);
    tick();
    q = '{8'd1};
    run_group(q, 8'd1, 1'b0, 0);

    send(8'd4, 1'b0, 1'b0);
    send(8'd4, 1'b1, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (vld8) begin
        ok = 1'b1;
        break;
      end
    end
    chk("clr_out_reached", ok, 1);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    @(negedge CLK);
    chk("clr_out_valid", vld8, 0);
    chk("clr_out_data", data8, 0);
    chk("clr_out_ready", rdy8, 1);
    tick();

    q = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    run_group(q, 8'd5, 1'b0, 0);
    run_group(q, 8'd5, 1'b1, 1);

    rand_group(300, 1'b0, 0);

    for (int g = 0; g < 8; g++)
      rand_group($urandom_range(1, 20), 1'b1, $urandom_range(0, 3));

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
